// File: rtl/vga_timing_gra_if.sv
// Timing bundle carried from the VGA timing generator to its consumers.
// The "out" modport is the view of the timing generator that drives it.
interface vga_if_tim;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gra.sv
// VGA raster timing generator: horizontal/vertical counters, sync and blank
// flags, and a frame-start pulse. All outputs are registered.
// The sync and blank flags are decoded from the next-state counter values, so
// they always describe the counts shown in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the 16-bit
// completed-frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gra #(
    parameter int HOR_TOTAL      = 1056,
    parameter int HOR_PIXELS     = 800,
    parameter int HOR_SYNC_START = 840,
    parameter int HOR_SYNC_STOP  = 968,
    parameter int VER_TOTAL      = 628,
    parameter int VER_PIXELS     = 600,
    parameter int VER_SYNC_START = 601,
    parameter int VER_SYNC_STOP  = 605
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if_tim.out      tim_if,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_LAST = 11'(HOR_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(VER_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(HOR_PIXELS);
    localparam logic [10:0] V_VIS  = 11'(VER_PIXELS);
    localparam logic [10:0] H_SS   = 11'(HOR_SYNC_START);
    localparam logic [10:0] H_SE   = 11'(HOR_SYNC_STOP);
    localparam logic [10:0] V_SS   = 11'(VER_SYNC_START);
    localparam logic [10:0] V_SE   = 11'(VER_SYNC_STOP);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic        h_wrap, v_wrap;

    // Next-state counters and flags; >= on the wrap test keeps the counters in
    // range even if a bad value were ever loaded.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        h_wrap        = (hcount_q >= H_LAST);
        v_wrap        = (vcount_q >= V_LAST);
        if (en) begin
            hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
            if (h_wrap) begin
                vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
            end
            frame_start_d = h_wrap && v_wrap;
        end
        hsync_d = (hcount_d >= H_SS) && (hcount_d < H_SE);
        vsync_d = (vcount_d >= V_SS) && (vcount_d < V_SE);
        hblnk_d = (hcount_d >= H_VIS);
        vblnk_d = (vcount_d >= V_VIS);
    end

    // Timing state register; reset clears everything without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, stepped on the same edge that raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    assign tim_if.hcount = hcount_q;
    assign tim_if.vcount = vcount_q;
    assign tim_if.hsync  = hsync_q;
    assign tim_if.vsync  = vsync_q;
    assign tim_if.hblnk  = hblnk_q;
    assign tim_if.vblnk  = vblnk_q;
    assign frame_start   = frame_start_q;

endmodule

// File: doc/vga_timing_gra.md
VGA_TIMING_GRA -- requirements
Module: vga_timing_gra

Interface
REQ-001 The module SHALL have parameter HOR_TOTAL, default 1056, meaning clocks per line.
REQ-002 The module SHALL have parameter HOR_PIXELS, default 800, meaning visible clocks per line.
REQ-003 The module SHALL have parameters HOR_SYNC_START / HOR_SYNC_STOP, defaults 840 / 968, meaning hsync high for hcount in [start, stop).
REQ-004 The module SHALL have parameter VER_TOTAL, default 628, meaning lines per frame.
REQ-005 The module SHALL have parameter VER_PIXELS, default 600, meaning visible lines per frame.
REQ-006 The module SHALL have parameters VER_SYNC_START / VER_SYNC_STOP, defaults 601 / 605, meaning vsync high for vcount in [start, stop).
REQ-007 Port clk, input, 1 bit: single pixel clock; all logic on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port en, input, 1 bit: pixel advance enable; counters hold while low.
REQ-010 Port tim_if, vga_if_tim.out: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk.
REQ-011 Port frame_start, output, 1 bit: one-cycle pulse when the counters wrap to (0,0).
REQ-012 Port frame_cnt, output, 16 bits: completed-frame counter.

Function
REQ-013 hcount SHALL increment by 1 on each clk edge with en=1 and SHALL wrap from HOR_TOTAL-1 to 0.
REQ-014 vcount SHALL increment by 1 only on the hcount wrap and SHALL wrap from VER_TOTAL-1 to 0 on the same edge.
REQ-015 hblnk SHALL be 1 exactly when hcount >= HOR_PIXELS; vblnk SHALL be 1 exactly when vcount >= VER_PIXELS.
REQ-016 hsync and vsync SHALL be active-high over the windows in REQ-003 and REQ-006.
REQ-017 All tim_if fields SHALL be registered and mutually consistent: sync/blank flags SHALL describe the hcount/vcount values presented in the same cycle (zero skew).
REQ-018 frame_start SHALL be 1 for exactly one en-qualified cycle, the cycle in which the outputs show hcount=0, vcount=0, and 0 otherwise.
REQ-019 When en=0, every output SHALL hold its value and frame_start SHALL be 0.
REQ-020 frame_cnt SHALL increment by 1 on each frame wrap (vcount VER_TOTAL-1 -> 0) and SHALL wrap from 16'hFFFF to 0.
REQ-021 The counters SHALL never take values >= HOR_TOTAL / VER_TOTAL, including the cycle after reset release.

Reset
REQ-022 On rst=1, the module SHALL immediately set hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_cnt=0, and frame_start=0, without waiting for a clk edge.
REQ-023 On the first en-qualified edge after rst falls, the outputs SHALL show hcount=1, vcount=0; frame_start SHALL NOT pulse for the reset state.
REQ-024 When reset is asserted mid-line or mid-frame, the module SHALL discard all state; no partial frame is counted in frame_cnt.

Configuration
REQ-025 Macro VGA_TIMING_FRAME_CNT_EN: when defined, frame_cnt SHALL behave per REQ-020.
REQ-026 When VGA_TIMING_FRAME_CNT_EN is not defined, frame_cnt SHALL be a constant 0, no counter register SHALL be synthesised, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Scenario: reset, then en=1 for 1056 clocks -> hcount runs 1..1055 then 0, vcount steps 0 -> 1 on the wrap, and hblnk is high for hcount 800..1055.
REQ-028 Scenario: run one full frame (1056*628 clocks) -> hsync high for hcount 840..967 on every line, vsync high for vcount 601..604, exactly one frame_start pulse, and frame_cnt=1 (macro defined).
REQ-029 Scenario: toggle en with a 50% random pattern for 2 frames -> the counter sequence equals the en=1 sequence with stalls inserted, outputs are frozen on en=0 cycles, and frame_start is never high while en=0.
REQ-030 Scenario: assert rst asynchronously at hcount=500, vcount=300 -> all outputs read 0 within the same cycle, and after release the count restarts from hcount=1, vcount=0.
REQ-031 Scenario: preload 65535 frames (force, or run with a reduced-parameter build) -> the next frame wrap gives frame_cnt=0; with the macro undefined, frame_cnt stays 0 throughout.
